// File: rtl/dds_sine_gen_if.sv
// Control and sample-stream bundle for dds_sine_gen.
// The master drives the controls and out_ready. The slave (the generator) returns the sample stream.
interface dds_sine_gen_if #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 16
);
  logic               en;
  logic               sync;
  logic [PHASE_W-1:0] freq_word;
  logic [1:0]         atten;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_sample;

  modport master (
    output en, sync, freq_word, atten, out_ready,
    input  out_valid, out_sample
  );

  modport slave (
    input  en, sync, freq_word, atten, out_ready,
    output out_valid, out_sample
  );
endinterface

// File: rtl/dds_sine_gen.sv
// DDS sine source: a phase accumulator feeds a quarter-wave ROM with quadrant folding.
// A two-stage valid/ready pipeline follows and produces offset-binary samples.
module dds_sine_gen #(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int OUT_W   = 16,
  parameter int AMP     = 1000,
  parameter int OFFSET  = 1000
) (
  input logic          clk,
  input logic          rst,
  dds_sine_gen_if.slave io
);
  localparam int N      = 1 << LUT_AW;
  localparam int AMP_W  = $clog2(AMP + 1);
  localparam int STAGES = 2;
  localparam int LOW_W  = PHASE_W - 2 - LUT_AW;
  localparam logic [LUT_AW:0]  N_IDX = {1'b1, {LUT_AW{1'b0}}};
  localparam logic [OUT_W-1:0] OFF   = OUT_W'(OFFSET);

  // Quarter-wave table q(k) = round(AMP*sin(pi/2*k/N)), built with a Taylor series.
  function automatic logic [(N+1)*AMP_W-1:0] build_rom();
    logic [(N+1)*AMP_W-1:0] r;
    real x, term, s;
    int  v;
    r = '0;
    for (int k = 0; k <= N; k++) begin
      x    = 1.5707963267948966 * k / N;
      s    = 0.0;
      term = x;
      for (int n = 1; n <= 21; n += 2) begin
        s    = s + term;
        term = -term * x * x / ((n + 1) * (n + 2));
      end
      v = $rtoi(AMP * s + 0.5);
      r[k*AMP_W +: AMP_W] = AMP_W'(v);
    end
    return r;
  endfunction

  localparam logic [(N+1)*AMP_W-1:0] ROM = build_rom();

  logic [STAGES:1]    vld_pipe_q, vld_pipe_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [AMP_W-1:0]   rom_q, rom_d;
  logic               neg_q, neg_d;
  logic [1:0]         atten_q, atten_d;
  logic [OUT_W-1:0]   sample_q, sample_d;

  logic               adv;
  logic [PHASE_W-1:0] cap_phase;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  k;
  logic [LUT_AW:0]    idx;
  logic [AMP_W-1:0]   rom_val;
  logic [OUT_W-1:0]   mag;
  logic [OUT_W-1:0]   result;

  assign adv       = ~vld_pipe_q[STAGES] | io.out_ready;
  assign cap_phase = io.sync ? '0 : phase_q;
  assign quad      = cap_phase[PHASE_W-1 -: 2];
  assign k         = cap_phase[PHASE_W-3 -: LUT_AW];
  // Odd quadrants read the table backwards; k=0 there lands on the peak entry N.
  assign idx       = quad[0] ? (N_IDX - {1'b0, k}) : {1'b0, k};
  assign rom_val   = ROM[idx*AMP_W +: AMP_W];
  assign mag       = OUT_W'(rom_q) >> atten_q;
  assign result    = neg_q ? (OFF - mag) : (OFF + mag);

  generate
    if (LOW_W > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^cap_phase[LOW_W-1:0];
    end
  endgenerate

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    phase_d    = phase_q;
    rom_d      = rom_q;
    neg_d      = neg_q;
    atten_d    = atten_q;
    sample_d   = sample_q;
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], io.en};
      if (vld_pipe_q[1]) sample_d = result;
      rom_d   = rom_val;
      neg_d   = quad[1];
      atten_d = io.atten;
      if (io.sync) phase_d = io.en ? io.freq_word : '0;
      else if (io.en) phase_d = phase_q + io.freq_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      phase_q    <= '0;
      rom_q      <= '0;
      neg_q      <= 1'b0;
      atten_q    <= '0;
      sample_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      phase_q    <= phase_d;
      rom_q      <= rom_d;
      neg_q      <= neg_d;
      atten_q    <= atten_d;
      sample_q   <= sample_d;
    end
  end

  assign io.out_valid  = vld_pipe_q[STAGES];
  assign io.out_sample = sample_q;
endmodule

// File: tb/tb_dds_sine_gen.sv
// Randomized scoreboard bench for dds_sine_gen.
// A trigonometric reference predicts each sample at issue time, and a negedge monitor consumes the predictions.
module tb_dds_sine_gen;
  localparam int PW  = 6;
  localparam int LA  = 4;
  localparam int OW  = 16;
  localparam int AMP = 1000;
  localparam int OFS = 1000;
  localparam int N   = 1 << LA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_sine_gen_if #(.PHASE_W(PW), .OUT_W(OW)) io();

  dds_sine_gen #(.PHASE_W(PW), .LUT_AW(LA), .OUT_W(OW), .AMP(AMP), .OFFSET(OFS)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int          checks = 0;
  int          errors = 0;
  int          exp_q[$];
  int          model_ph = 0;
  logic        stall_prev = 1'b0;
  logic [OW-1:0] prev_s = '0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // The sample is AMP*sin of the phase angle quantized to 4N points, rounded, attenuated, then offset.
  function automatic int ref_sample(int ph, int att);
    int  m, mag;
    real s;
    m = ph >> (PW - 2 - LA);
    s = $sin(2.0 * 3.14159265358979 * m / (4 * N));
    if (s < 0.0) s = -s;
    mag = $rtoi(AMP * s + 0.5) >> att;
    return (m >= 2 * N) ? OFS - mag : OFS + mag;
  endfunction

  task automatic step(bit en, bit sy, int fw, int att, bit rdy);
    bit adv;
    int cap, w;
    w = fw % (1 << PW);
    io.en        = en;
    io.sync      = sy;
    io.freq_word = w[PW-1:0];
    io.atten     = att[1:0];
    io.out_ready = rdy;
    adv = !io.out_valid || rdy;
    if (adv) begin
      cap = sy ? 0 : model_ph;
      if (en) exp_q.push_back(ref_sample(cap, att));
      if (sy) model_ph = en ? w : 0;
      else if (en) model_ph = (model_ph + w) % (1 << PW);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    io.en        = 1'b0;
    io.sync      = 1'b0;
    io.freq_word = '0;
    io.atten     = '0;
    io.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", int'(io.out_valid), 0);
    chk("rst_sample", int'(io.out_sample), 0);
    exp_q.delete();
    model_ph = 0;
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", int'(io.out_valid), 1);
          chk("hold_sample", int'(io.out_sample), int'(prev_s));
        end
        if (io.out_valid && io.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got %0d expected none", io.out_sample);
          end else begin
            chk("sample", int'(io.out_sample), exp_q.pop_front());
          end
        end
        stall_prev = io.out_valid && !io.out_ready;
        prev_s     = io.out_sample;
      end
    end
  end

  initial begin
    int att_l[3] = '{0, 1, 3};
    int fw_keep;
    do_reset();
    do_reset();

    // Two-cycle latency, then a full wrap with freq_word=1.
    step(1, 0, 1, 0, 1);
    chk("lat_v1", int'(io.out_valid), 0);
    step(1, 0, 1, 0, 1);
    chk("lat_v2", int'(io.out_valid), 1);
    chk("lat_s2", int'(io.out_sample), 1000);
    for (int i = 0; i < 68; i++) step(1, 0, 1, 0, 1);

    // Back-pressure for three cycles.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 1);

    // Mid-stream sync pulse.
    step(1, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 1);

    // Quarter-period steps at each attenuation.
    foreach (att_l[a]) begin
      step(1, 1, 16, att_l[a], 1);
      for (int i = 0; i < 8; i++) step(1, 0, 16, att_l[a], 1);
    end

    // Word switch 1 -> 16 on a live stream.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 16, 0, 1);

    // sync with en=0, then en low draining.
    step(0, 1, 5, 0, 1);
    step(0, 0, 5, 0, 1);
    step(0, 0, 5, 0, 1);
    chk("idle_valid", int'(io.out_valid), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 3, 2, 1);

    // Reset mid-stream and restart.
    do_reset();
    step(1, 0, 1, 0, 1);
    chk("rlat_v1", int'(io.out_valid), 0);
    step(1, 0, 1, 0, 1);
    chk("rlat_v2", int'(io.out_valid), 1);
    chk("rlat_s2", int'(io.out_sample), 1000);

    // Randomized stream.
    fw_keep = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) fw_keep = $urandom_range(0, 63);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
           fw_keep, $urandom_range(0, 3), $urandom_range(0, 9) < 7);
    end

    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", int'(io.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
